// File: rtl/error_inject_ctrl_pkg.sv
// Shared constants and types for the codeword error injector.
package error_inject_ctrl_pkg;

  localparam int          CW_WIDTH  = 38;
  localparam int          POS_W     = 6;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps for the right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_DOUBLE = 2'b10,
    MODE_FIXED  = 2'b11
  } inj_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } inj_state_e;

  // One LFSR advance: feedback enters at the top, state shifts toward bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = ^(v & LFSR_TAPS);
    lfsr_next = {fb, v[15:1]};
  endfunction

endpackage

// File: rtl/error_inject_ctrl_lfsr.sv
// 16-bit Fibonacci LFSR that supplies pseudo-random bit positions.
module inj_lfsr16
  import error_inject_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] lfsr_d;
  logic [15:0] lfsr_q;

  // Advance once per step request, otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // State register; reset loads the seed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/error_inject_ctrl.sv
// Fault injector between Hamming encoder and decoder: one register stage
// that flips one or two codeword bits according to the latched run config.
module error_inject_ctrl #(
  parameter int          CW_WIDTH  = error_inject_ctrl_pkg::CW_WIDTH,
  parameter int          POS_W     = error_inject_ctrl_pkg::POS_W,
  parameter logic [15:0] LFSR_SEED = error_inject_ctrl_pkg::LFSR_SEED
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_en,
  input  logic [1:0]          cfg_mode,
  input  logic [7:0]          cfg_period,
  input  logic [7:0]          cfg_count,
  input  logic [POS_W-1:0]    cfg_fixed_pos,
  input  logic                in_valid,
  input  logic [CW_WIDTH-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [CW_WIDTH-1:0] out_data,
  output logic [CW_WIDTH-1:0] out_err_mask,
  output logic                out_injected,
  input  logic                out_ready,
  output logic [15:0]         inj_cnt,
  output logic                done
);

  import error_inject_ctrl_pkg::*;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(CW_WIDTH - 1);

  // Positions 38..63 fold back into range so the LFSR never picks a dead bit.
  function automatic logic [POS_W-1:0] wrap_pos(input logic [POS_W-1:0] v);
    if (v >= POS_W'(CW_WIDTH)) wrap_pos = v - POS_W'(CW_WIDTH);
    else                       wrap_pos = v;
  endfunction

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v);
    if (v > LAST_POS) clamp_pos = LAST_POS;
    else              clamp_pos = v;
  endfunction

  function automatic logic [CW_WIDTH-1:0] one_hot(input logic [POS_W-1:0] p);
    one_hot = {{(CW_WIDTH-1){1'b0}}, 1'b1} << p;
  endfunction

  inj_state_e          state_d, state_q;
  inj_mode_e           mode_d, mode_q;
  logic [7:0]          period_d, period_q;
  logic [7:0]          count_d, count_q;
  logic [POS_W-1:0]    fixed_pos_d, fixed_pos_q;
  logic [7:0]          period_cnt_d, period_cnt_q;
  logic [7:0]          run_cnt_d, run_cnt_q;
  logic [15:0]         inj_cnt_d, inj_cnt_q;
  logic                done_d, done_q;
  logic                out_valid_d, out_valid_q;
  logic [CW_WIDTH-1:0] out_data_d, out_data_q;
  logic [CW_WIDTH-1:0] out_mask_d, out_mask_q;
  logic                out_inj_d, out_inj_q;

  logic                accept;
  logic                run_active;
  logic                eligible;
  logic                inject;
  logic                lfsr_step;
  logic [15:0]         lfsr_val;
  logic [POS_W-1:0]    p0, p1_raw, p1;
  logic [CW_WIDTH-1:0] mode_mask;
  logic [CW_WIDTH-1:0] inj_mask;
  logic                unused_lfsr_hi;

  assign in_ready       = !out_valid_q || out_ready;
  assign accept         = in_valid && in_ready;
  assign run_active     = (state_q == ST_RUN) && (mode_q != MODE_OFF);
  assign eligible       = run_active && (period_cnt_q == period_q);
  assign inject         = accept && eligible;
  // The generator advances on every codeword accepted in RUN, injected or not.
  assign lfsr_step      = accept && (state_q == ST_RUN);
  assign unused_lfsr_hi = ^lfsr_val[15:12];

  inj_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (lfsr_step),
    .seed  (LFSR_SEED),
    .value (lfsr_val)
  );

  // Build the candidate mask from the pre-step LFSR value and the latched mode.
  always_comb begin
    p0     = wrap_pos(lfsr_val[POS_W-1:0]);
    p1_raw = wrap_pos(lfsr_val[2*POS_W-1:POS_W]);
    if (p1_raw == p0) begin
      p1 = (p0 == LAST_POS) ? {POS_W{1'b0}} : p0 + POS_W'(1);
    end else begin
      p1 = p1_raw;
    end
    case (mode_q)
      MODE_SINGLE: mode_mask = one_hot(p0);
      MODE_DOUBLE: mode_mask = one_hot(p0) | one_hot(p1);
      MODE_FIXED:  mode_mask = one_hot(clamp_pos(fixed_pos_q));
      default:     mode_mask = {CW_WIDTH{1'b0}};
    endcase
    if (eligible) begin
      inj_mask = mode_mask;
    end else begin
      inj_mask = {CW_WIDTH{1'b0}};
    end
  end

  // FSM next state, config latch and run/period/total counters.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    period_d     = period_q;
    count_d      = count_q;
    fixed_pos_d  = fixed_pos_q;
    period_cnt_d = period_cnt_q;
    run_cnt_d    = run_cnt_q;
    inj_cnt_d    = inj_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_en) begin
          state_d     = ST_RUN;
          mode_d      = inj_mode_e'(cfg_mode);
          period_d    = cfg_period;
          count_d     = cfg_count;
          fixed_pos_d = cfg_fixed_pos;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!cfg_en) begin
          state_d = ST_IDLE;
        end else if (inject && (count_q != 8'd0) && (run_cnt_q + 8'd1 == count_q)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!cfg_en) state_d = ST_IDLE;
        else         state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept && run_active) begin
      period_cnt_d = eligible ? 8'd0 : period_cnt_q + 8'd1;
    end else begin
      period_cnt_d = period_cnt_q;
    end

    if (inject) begin
      run_cnt_d = run_cnt_q + 8'd1;
      inj_cnt_d = (inj_cnt_q == 16'hFFFF) ? inj_cnt_q : inj_cnt_q + 16'd1;
    end else begin
      run_cnt_d = run_cnt_q;
      inj_cnt_d = inj_cnt_q;
    end

    // Leaving a run always restarts its bookkeeping; totals and LFSR survive.
    if (state_d == ST_IDLE) begin
      period_cnt_d = 8'd0;
      run_cnt_d    = 8'd0;
    end else begin
      period_cnt_d = period_cnt_d;
    end

    done_d = (state_d == ST_DONE);
  end

  // Output stage: capture on accept, drain on out_ready, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_inj_d   = out_inj_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ inj_mask;
      out_mask_d  = inj_mask;
      out_inj_d   = |inj_mask;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // All state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_OFF;
      period_q     <= 8'd0;
      count_q      <= 8'd0;
      fixed_pos_q  <= {POS_W{1'b0}};
      period_cnt_q <= 8'd0;
      run_cnt_q    <= 8'd0;
      inj_cnt_q    <= 16'd0;
      done_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= {CW_WIDTH{1'b0}};
      out_mask_q   <= {CW_WIDTH{1'b0}};
      out_inj_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      period_q     <= period_d;
      count_q      <= count_d;
      fixed_pos_q  <= fixed_pos_d;
      period_cnt_q <= period_cnt_d;
      run_cnt_q    <= run_cnt_d;
      inj_cnt_q    <= inj_cnt_d;
      done_q       <= done_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_mask_q   <= out_mask_d;
      out_inj_q    <= out_inj_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_err_mask = out_mask_q;
  assign out_injected = out_inj_q;
  assign inj_cnt      = inj_cnt_q;
  assign done         = done_q;

endmodule

// File: tb/tb_error_inject_ctrl.sv
// Directed, table-driven bench for error_inject_ctrl.
module tb_error_inject_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_period;
  logic [7:0]  cfg_count;
  logic [5:0]  cfg_fixed_pos;
  logic        in_valid;
  logic [37:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [37:0] out_data;
  logic [37:0] out_err_mask;
  logic        out_injected;
  logic        out_ready;
  logic [15:0] inj_cnt;
  logic        done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic        new_run;
    logic [1:0]  mode;
    logic [7:0]  period;
    logic [7:0]  count;
    logic [5:0]  fpos;
    logic [37:0] data;
    logic [37:0] exp_mask;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  // Hand-derived LFSR masks from seed ACE1 (pre-step values ACE1, 5670, AB38, 559C).
  localparam logic [37:0] DM1 = 38'h02_0000_2000;  // bits 33,13
  localparam logic [37:0] DM2 = 38'h00_0200_0400;  // bits 25,10
  localparam logic [37:0] DM3 = 38'h00_0004_0040;  // bits 18,6
  localparam logic [37:0] DM4 = 38'h00_1040_0000;  // bits 28,22
  localparam logic [37:0] B5  = 38'h00_0000_0020;
  localparam logic [37:0] B37 = 38'h20_0000_0000;

  always #5 clk = ~clk;

  error_inject_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_en        (cfg_en),
    .cfg_mode      (cfg_mode),
    .cfg_period    (cfg_period),
    .cfg_count     (cfg_count),
    .cfg_fixed_pos (cfg_fixed_pos),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_err_mask  (out_err_mask),
    .out_injected  (out_injected),
    .out_ready     (out_ready),
    .inj_cnt       (inj_cnt),
    .done          (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [37:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic add(input logic nr, input logic [1:0] m, input logic [7:0] per,
                     input logic [7:0] cnt, input logic [5:0] fp, input logic [37:0] d,
                     input logic [37:0] em, input logic ed);
    vec_t v;
    v.new_run = nr; v.mode = m; v.period = per; v.count = cnt; v.fpos = fp;
    v.data = d; v.exp_mask = em; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  initial begin
    int exp_inj;
    vec_t v;

    // Group A: double random, period 0, count 4 (starts from the reset seed).
    add(1'b1, 2'b10, 8'd0, 8'd4, 6'd0, 38'h00_0000_0000, DM1, 1'b0);
    add(1'b0, 2'b10, 8'd0, 8'd4, 6'd0, 38'h3F_FFFF_FFFF, DM2, 1'b0);
    add(1'b0, 2'b10, 8'd0, 8'd4, 6'd0, 38'h15_5555_5555, DM3, 1'b0);
    add(1'b0, 2'b10, 8'd0, 8'd4, 6'd0, 38'h00_0000_0000, DM4, 1'b1);
    for (int i = 0; i < 4; i++)
      add(1'b0, 2'b10, 8'd0, 8'd4, 6'd0, 38'h2A_AAAA_AAAA, 38'h0, 1'b1);
    // Group B: mode off, ten codewords pass through untouched.
    for (int i = 0; i < 10; i++)
      add(i == 0, 2'b00, 8'd0, 8'd0, 6'd5, 38'(i * 32'h1357_9BDF), 38'h0, 1'b0);
    // Group C: fixed bit 5, period 2: words 3, 6, 9 only.
    for (int i = 1; i <= 9; i++)
      add(i == 1, 2'b11, 8'd2, 8'd0, 6'd5, 38'h0, (i % 3 == 0) ? B5 : 38'h0, 1'b0);
    // Group D: fixed position 50 clamps to bit 37 on every word.
    for (int i = 0; i < 3; i++)
      add(i == 0, 2'b11, 8'd0, 8'd0, 6'd50, 38'h01_0F0F_0F0F, B37, 1'b0);

    rst_n = 1'b0; cfg_en = 1'b0; cfg_mode = 2'b00; cfg_period = 8'd0; cfg_count = 8'd0;
    cfg_fixed_pos = 6'd0; in_valid = 1'b0; in_data = 38'h0; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mask", 64'(out_err_mask), 64'd0);
    chk("rst_injected", 64'(out_injected), 64'd0);
    chk("rst_inj_cnt", 64'(inj_cnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    exp_inj = 0;
    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.new_run) begin
        cfg_en = 1'b0;
        tick();
        chk($sformatf("vec%0d_done_clear", i), 64'(done), 64'd0);
        cfg_mode = v.mode; cfg_period = v.period; cfg_count = v.count; cfg_fixed_pos = v.fpos;
        cfg_en = 1'b1;
        tick();
      end
      push(v.data);
      if (v.exp_mask != 38'h0) exp_inj++;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(v.data ^ v.exp_mask));
      chk($sformatf("vec%0d_mask", i), 64'(out_err_mask), 64'(v.exp_mask));
      chk($sformatf("vec%0d_injected", i), 64'(out_injected), 64'(v.exp_mask != 38'h0));
      chk($sformatf("vec%0d_inj_cnt", i), 64'(inj_cnt), 64'(exp_inj));
      chk($sformatf("vec%0d_done", i), 64'(done), 64'(v.exp_done));
    end

    // Backpressure: single random from the seed; a stall must not step the LFSR.
    rst_n = 1'b0; cfg_en = 1'b1; cfg_mode = 2'b01; cfg_period = 8'd0; cfg_count = 8'd0;
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b0;
    push(38'h15_5555_5555);
    chk("bp_first_mask", 64'(out_err_mask), 64'(38'h02_0000_0000));
    in_valid = 1'b1;
    in_data  = 38'h0A_AAAA_AAAA;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'd0);
      chk($sformatf("bp%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d_data", k), 64'(out_data), 64'(38'h15_5555_5555 ^ 38'h02_0000_0000));
      chk($sformatf("bp%0d_mask", k), 64'(out_err_mask), 64'(38'h02_0000_0000));
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_second_data", 64'(out_data), 64'(38'h0A_AAAA_AAAA ^ 38'h00_0000_0400));
    chk("bp_second_mask", 64'(out_err_mask), 64'(38'h00_0000_0400));
    chk("bp_inj_cnt", 64'(inj_cnt), 64'd2);

    // Reset while a codeword is held, then replay the first double-random masks.
    out_ready = 1'b0;
    chk("mid_rst_held", 64'(out_valid), 64'd1);
    cfg_mode = 2'b10; cfg_period = 8'd0; cfg_count = 8'd4;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_inj_cnt", 64'(inj_cnt), 64'd0);
    chk("mid_rst_mask", 64'(out_err_mask), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    push(38'h0);
    chk("replay1_mask", 64'(out_err_mask), 64'(DM1));
    push(38'h0);
    chk("replay2_mask", 64'(out_err_mask), 64'(DM2));
    chk("replay_inj_cnt", 64'(inj_cnt), 64'd2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
